// File: rtl/seg_scan_if.sv
// Bundle between the value source / display pins and the BCD scan driver.
// master: whoever supplies value/load/blank_lz. slave: the driver itself.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BIN_WIDTH  = 16
);
    logic [BIN_WIDTH-1:0]  value;
    logic                  load;
    logic                  blank_lz;
    logic [3:0]            digit;
    logic [NUM_DIGITS-1:0] anode;
    logic                  busy;
    logic                  conv_done;
    logic [1:0]            dbg_state;

    // Handshake: load is taken on a rising edge only while busy is low.
    // No ready/ack is returned; a load seen while busy is dropped.
    modport master (
        output value, load, blank_lz,
        input  digit, anode, busy, conv_done, dbg_state
    );

    modport slave (
        input  value, load, blank_lz,
        output digit, anode, busy, conv_done, dbg_state
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD double-dabble converter feeding a time-multiplexed,
// active-low-anode digit scanner with optional leading-zero blanking.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int BIN_WIDTH   = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIN_WIDTH-1:0] r_bin;
    logic [BIN_WIDTH-1:0] w_bin_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BCD_W-1:0]   r_disp;
    logic [BCD_W-1:0]   w_disp_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic [DIV_W-1:0]      r_div;
    logic                  w_tick;
    logic [IDX_W-1:0]      r_idx;
    logic [BCD_W-1:0]      w_upper;
    logic                  w_blank;
    logic [3:0]            r_digit;
    logic [NUM_DIGITS-1:0] r_anode;

    // Double-dabble correction: any nibble >= 5 would overflow past 9 when doubled.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_bcd   <= w_bcd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_disp  <= w_disp_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_bcd_nxt   = r_bcd;
        w_cnt_nxt   = r_cnt;
        w_disp_nxt  = r_disp;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_bin_nxt   = bus.value;
                    w_bcd_nxt   = '0;
                    w_cnt_nxt   = CNT_W'(BIN_WIDTH);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {w_bcd_nxt, w_bin_nxt} = {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Display register is only ever written here, so the scanner
                // never sees a half-converted accumulator.
                w_disp_nxt  = r_bcd;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_tick = (r_div == DIV_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Nibbles at and above the scanned position; all-zero means a leading zero.
    assign w_upper = r_disp >> {r_idx, 2'b00};
    assign w_blank = bus.blank_lz && (r_idx != '0) && (w_upper == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'h0;
            r_anode <= '1;
        end else if (w_blank) begin
            r_digit <= 4'hF;
            r_anode <= '1;
        end else begin
            r_digit <= w_upper[3:0];
            r_anode <= ~(NUM_DIGITS'(1) << r_idx);
        end
    end

    assign bus.digit     = r_digit;
    assign bus.anode     = r_anode;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.conv_done = r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Upstream stage of the BCD-to-7-segment decoder on the game-of-life board display. Converts a binary value (e.g. generation count) to packed BCD with a sequential double-dabble engine, then time-multiplexes the digits across the 8-digit common-anode display. It drives the 4-bit BCD `digit` into the decoder and the active-low `anode` enables directly to the pins.

Parameters:
NUM_DIGITS, 8, number of display digits scanned. Must satisfy 4*NUM_DIGITS >= BCD width of 2^BIN_WIDTH-1.
BIN_WIDTH, 16, width of binary input value.
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz). Must be >= 2.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
value  in  BIN_WIDTH  binary number to display; sampled only on accepted load
load  in  1  request conversion of value; accepted only in IDLE
blank_lz  in  1  1 = blank leading zero digits (digit 0 never blanked)
digit  out  4  BCD nibble of currently scanned digit, to decoder
anode  out  NUM_DIGITS  active-low digit enables, at most one bit low
busy  out  1  conversion in progress (state != IDLE)
conv_done  out  1  one-cycle pulse: new value latched into display register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift reg/BCD accum=0, display reg=0, scan index=0, divider=0. Outputs: anode=all ones, digit=0, busy=0, conv_done=0.
- Converter FSM: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: on load=1 at edge, capture value into shift reg, clear BCD accum, bit counter=BIN_WIDTH, go SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1. Decrement counter; after BIN_WIDTH shifts go DONE.
- DONE: copy BCD accum to display reg, assert conv_done for this cycle only, go IDLE.
- Latency: load sampled at edge E; conv_done high and display reg updated at edge E+BIN_WIDTH+1 (E+17 for default). busy high from E through the DONE cycle.
- load while busy: ignored, no queuing; value change while busy: no effect.
- load in the cycle busy returns to 0: accepted normally, back-to-back conversions allowed.
- Display reg changes only in DONE, never mid-conversion; scanner never shows partial results.
- Scanner divider counts 0..REFRESH_DIV-1. At terminal count: divider wraps to 0, index increments, NUM_DIGITS-1 wraps to 0.
- digit and anode are registered from the current index (1-cycle latency). Output: digit=display nibble[index]; anode[index]=0, others 1.
- One cycle after reset release, anode=~1 (digit 0 enabled), digit=0.
- Leading-zero blank (blank_lz=1): digit i>0 is blanked if it and all higher nibbles are 0. When blanked, anode=all ones and digit=4'hF. Blanking is evaluated on the display reg. Value 0 shows a single "0".
- Scanner runs independently of the converter; simultaneous tick and DONE are both handled, and the new value is shown from the next registered output.
- Reset mid-conversion: abort, display reg=0, no conv_done.

Test Plan:
Sim REFRESH_DIV=4, defaults otherwise.
1. Reset then release -> anode=8'hFE, digit=0 after 1 cycle; busy=0; index advances every 4 cycles, anode walks FE,FD,FB..7F,FE.
2. load value=16'd12345, blank_lz=0 -> conv_done exactly 17 edges after load edge. Digits 0..7 = 5,4,3,2,1,0,0,0.
3. value=16'd65535 -> display 6,5,5,3,5. value=0 with blank_lz=1 -> only anode[0] ever low, digit=0; slots 1..7 show anode=FF, digit=F.
4. value=16'd907, blank_lz=1 -> digits 7,0,9 shown (middle zero not blanked); slots 3..7 anode=FF.
5. load 42, then load 99 at cycle 5 while busy -> second ignored, display=42, single conv_done. load 99 after busy=0 -> display=99.
6. Assert rst_n=0 at shift cycle 8 of a conversion -> immediate anode=FF, busy=0. No conv_done after release; display shows 0.
